// File: rtl/rx_dma_chan_filter_pkg.sv
// -----------------------------------------------------------------------------
// rx_dma_chan_filter_pkg
// Shared types and constants for the RX DMA channel filter:
//   - state_t        : packet-tracking FSM states
//   - sof_pos_width  : width of the SOF block index (at least 1 bit, so that
//                      REGION_SIZE = 1 still yields a legal port)
//   - META field layout of the packed input metadata {channel, hdr_meta}
// -----------------------------------------------------------------------------
package rx_dma_chan_filter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam int HDR_META_W   = 24;
   localparam int HDR_META_LSB = 0;
   localparam int CHAN_LSB     = 24;

   function automatic int sof_pos_width(input int region_size);
      int w;
      if (region_size > 1) begin
         w = $clog2(region_size);
      end else begin
         w = 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/rx_dma_chan_filter_sat_cntr.sv
// -----------------------------------------------------------------------------
// sat_cntr
// Saturating up-counter with synchronous clear.
// When clear and increment coincide, the counter restarts at 1 so that the
// event being counted in the clear cycle is not lost.
// Ports:
//   CLK, RESET : clock, synchronous active-high reset
//   i_inc      : count one event
//   i_clr      : synchronous clear
//   o_value    : current count (sticks at all-ones)
// -----------------------------------------------------------------------------
module sat_cntr #(
   parameter int WIDTH = 32
)(
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [WIDTH-1:0] o_value
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_value;

   // counter register: clear wins over hold, increment stops at all-ones
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_value <= '0;
      end else if (i_clr) begin
         r_value <= i_inc ? ONE : '0;
      end else if (i_inc && (r_value != '1)) begin
         r_value <= r_value + ONE;
      end else begin
         r_value <= r_value;
      end
   end

   assign o_value = r_value;

endmodule

// File: rtl/rx_dma_chan_filter.sv
// -----------------------------------------------------------------------------
// rx_dma_chan_filter
// Sits in front of the RX DMA on the user MFB path (single region). Splits the
// packed metadata into channel and 24-bit header metadata, drops whole packets
// addressed to invalid or disabled channels, counts passed/dropped packets
// (saturating) and presents the surviving words through one registered stage
// with full backpressure.
// Ports:
//   CLK, RESET                  : clock, synchronous active-high reset
//   RX_MFB_*                    : input MFB word, META = {channel, hdr_meta}
//   RX_MFB_DST_RDY              : input ready (free or draining output stage)
//   TX_MFB_DATA/SOF_POS/EOF_POS/SOF/EOF : registered copy of a forwarded word
//   TX_MFB_META_CHAN/HDR_META   : metadata latched at the packet's SOF
//   TX_MFB_SRC_RDY/DST_RDY      : output valid / downstream ready
//   CHAN_ENABLE                 : per-channel enable, sampled at SOF only
//   CNT_CLR                     : synchronous clear of both counters
//   PASS_CNT / DROP_CNT         : forwarded / dropped packet counters
// -----------------------------------------------------------------------------
module rx_dma_chan_filter
   import rx_dma_chan_filter_pkg::*;
#(
   parameter int REGION_SIZE = 8,
   parameter int BLOCK_SIZE  = 8,
   parameter int ITEM_WIDTH  = 8,
   parameter int CHANNELS    = 16,
   parameter int CNTRS_WIDTH = 32
)(
   input  logic                                          CLK,
   input  logic                                          RESET,

   input  logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0]  RX_MFB_DATA,
   input  logic [HDR_META_W+$clog2(CHANNELS)-1:0]        RX_MFB_META,
   input  logic [sof_pos_width(REGION_SIZE)-1:0]         RX_MFB_SOF_POS,
   input  logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]     RX_MFB_EOF_POS,
   input  logic                                          RX_MFB_SOF,
   input  logic                                          RX_MFB_EOF,
   input  logic                                          RX_MFB_SRC_RDY,
   output logic                                          RX_MFB_DST_RDY,

   output logic [REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH-1:0]  TX_MFB_DATA,
   output logic [$clog2(CHANNELS)-1:0]                   TX_MFB_META_CHAN,
   output logic [HDR_META_W-1:0]                         TX_MFB_META_HDR_META,
   output logic [sof_pos_width(REGION_SIZE)-1:0]         TX_MFB_SOF_POS,
   output logic [$clog2(REGION_SIZE*BLOCK_SIZE)-1:0]     TX_MFB_EOF_POS,
   output logic                                          TX_MFB_SOF,
   output logic                                          TX_MFB_EOF,
   output logic                                          TX_MFB_SRC_RDY,
   input  logic                                          TX_MFB_DST_RDY,

   input  logic [CHANNELS-1:0]                           CHAN_ENABLE,
   input  logic                                          CNT_CLR,
   output logic [CNTRS_WIDTH-1:0]                        PASS_CNT,
   output logic [CNTRS_WIDTH-1:0]                        DROP_CNT
);

   localparam int DATA_W    = REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH;
   localparam int CHAN_W    = $clog2(CHANNELS);
   localparam int SOF_POS_W = sof_pos_width(REGION_SIZE);
   localparam int EOF_POS_W = $clog2(REGION_SIZE*BLOCK_SIZE);
   // enable vector widened to every encodable channel number; the extra
   // entries are zero so channels >= CHANNELS read as disabled
   localparam int EN_EXT_W  = 2**CHAN_W;

   state_t                 r_state;
   state_t                 w_next_state;

   logic                   r_out_vld;
   logic [DATA_W-1:0]      r_data;
   logic [SOF_POS_W-1:0]   r_sof_pos;
   logic [EOF_POS_W-1:0]   r_eof_pos;
   logic                   r_sof;
   logic                   r_eof;
   logic [CHAN_W-1:0]      r_chan;
   logic [HDR_META_W-1:0]  r_hdr_meta;

   logic                   w_dst_rdy;
   logic                   w_acc;
   logic [CHAN_W-1:0]      w_chan;
   logic [HDR_META_W-1:0]  w_hdr_meta;
   logic [EN_EXT_W-1:0]    w_en_ext;
   logic                   w_drop;
   logic                   w_fwd;
   logic                   w_inc_pass;
   logic                   w_inc_drop;

   // Ready ignores the metadata: dropped words stall exactly like passed ones.
   assign w_dst_rdy  = !r_out_vld || TX_MFB_DST_RDY;
   assign w_acc      = RX_MFB_SRC_RDY && w_dst_rdy;

   assign w_chan     = RX_MFB_META[CHAN_LSB +: CHAN_W];
   assign w_hdr_meta = RX_MFB_META[HDR_META_LSB +: HDR_META_W];
   assign w_en_ext   = EN_EXT_W'(CHAN_ENABLE);
   assign w_drop     = !w_en_ext[w_chan];

   // packet-tracking state register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next state, forward decision and counter strobes
   always_comb begin
      w_next_state = r_state;
      w_fwd        = 1'b0;
      w_inc_pass   = 1'b0;
      w_inc_drop   = 1'b0;
      if (w_acc) begin
         if (RX_MFB_SOF) begin
            // any SOF (even inside a packet) starts a fresh decision
            w_fwd      = !w_drop;
            w_inc_pass = !w_drop;
            w_inc_drop = w_drop;
            if (RX_MFB_EOF) begin
               w_next_state = IDLE;
            end else if (w_drop) begin
               w_next_state = DROP;
            end else begin
               w_next_state = PASS;
            end
         end else begin
            case (r_state)
               PASS: begin
                  w_fwd        = 1'b1;
                  w_next_state = RX_MFB_EOF ? IDLE : PASS;
               end
               DROP: begin
                  w_next_state = RX_MFB_EOF ? IDLE : DROP;
               end
               IDLE: begin
                  // orphan word without a preceding SOF: discarded
                  w_next_state = IDLE;
               end
               default: begin
                  w_next_state = IDLE;
               end
            endcase
         end
      end else begin
         w_next_state = r_state;
      end
   end

   // output stage: load forwarded words, retire the held word when taken
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_out_vld <= 1'b0;
         r_data    <= '0;
         r_sof_pos <= '0;
         r_eof_pos <= '0;
         r_sof     <= 1'b0;
         r_eof     <= 1'b0;
      end else if (w_fwd) begin
         r_out_vld <= 1'b1;
         r_data    <= RX_MFB_DATA;
         r_sof_pos <= RX_MFB_SOF_POS;
         r_eof_pos <= RX_MFB_EOF_POS;
         r_sof     <= RX_MFB_SOF;
         r_eof     <= RX_MFB_EOF;
      end else if (TX_MFB_DST_RDY) begin
         r_out_vld <= 1'b0;
      end else begin
         r_out_vld <= r_out_vld;
      end
   end

   // metadata captured at every accepted SOF and held until the next one;
   // an accepted SOF implies the output stage is free or being drained, so
   // the held word never sees the metadata of a later packet
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_chan     <= '0;
         r_hdr_meta <= '0;
      end else if (w_acc && RX_MFB_SOF) begin
         r_chan     <= w_chan;
         r_hdr_meta <= w_hdr_meta;
      end else begin
         r_chan     <= r_chan;
         r_hdr_meta <= r_hdr_meta;
      end
   end

   sat_cntr #(
      .WIDTH   (CNTRS_WIDTH)
   ) u_pass_cntr (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_inc   (w_inc_pass),
      .i_clr   (CNT_CLR),
      .o_value (PASS_CNT)
   );

   sat_cntr #(
      .WIDTH   (CNTRS_WIDTH)
   ) u_drop_cntr (
      .CLK     (CLK),
      .RESET   (RESET),
      .i_inc   (w_inc_drop),
      .i_clr   (CNT_CLR),
      .o_value (DROP_CNT)
   );

   assign RX_MFB_DST_RDY       = w_dst_rdy;
   assign TX_MFB_SRC_RDY       = r_out_vld;
   assign TX_MFB_DATA          = r_data;
   assign TX_MFB_SOF_POS       = r_sof_pos;
   assign TX_MFB_EOF_POS       = r_eof_pos;
   assign TX_MFB_SOF           = r_sof;
   assign TX_MFB_EOF           = r_eof;
   assign TX_MFB_META_CHAN     = r_chan;
   assign TX_MFB_META_HDR_META = r_hdr_meta;

endmodule

// File: tb/tb_rx_dma_chan_filter.sv
// -----------------------------------------------------------------------------
// tb_rx_dma_chan_filter
// Self-checking bench: directed steps plus randomized packets. A packet-level
// reference model (queue of expected output words, per-packet pass/drop flag,
// saturating counter values) predicts every output at each falling edge.
// Built with CHANNELS = 12 (channels 12..15 are invalid) and CNTRS_WIDTH = 4.
// -----------------------------------------------------------------------------
module tb_rx_dma_chan_filter;

   localparam int NCH   = 12;
   localparam int CW    = 4;
   localparam int CMAX  = 15;

   typedef struct {
      logic [511:0] data;
      logic [2:0]   sp;
      logic [5:0]   ep;
      logic         sof;
      logic         eof;
      logic [3:0]   chan;
      logic [23:0]  hdr;
   } word_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [511:0]  rx_data = '0;
   logic [27:0]   rx_meta = '0;
   logic [2:0]    rx_sof_pos = '0;
   logic [5:0]    rx_eof_pos = '0;
   logic          rx_sof = 1'b0;
   logic          rx_eof = 1'b0;
   logic          rx_src_rdy = 1'b0;
   logic          rx_dst_rdy;
   logic [511:0]  tx_data;
   logic [3:0]    tx_chan;
   logic [23:0]   tx_hdr;
   logic [2:0]    tx_sof_pos;
   logic [5:0]    tx_eof_pos;
   logic          tx_sof;
   logic          tx_eof;
   logic          tx_src_rdy;
   logic          tx_dst_rdy = 1'b1;
   logic [NCH-1:0] chan_en = '1;
   logic          cnt_clr = 1'b0;
   logic [CW-1:0] pass_cnt;
   logic [CW-1:0] drop_cnt;

   int    errors = 0;
   int    checks = 0;
   bit    tx_rand = 1'b0;
   bit    last_acc = 1'b0;

   // reference model state
   word_t exp_q[$];
   bit    in_pkt = 1'b0;
   bit    pkt_pass = 1'b0;
   logic [3:0]  m_chan = '0;
   logic [23:0] m_hdr = '0;
   int    m_pass = 0;
   int    m_drop = 0;

   always #5 clk = ~clk;

   rx_dma_chan_filter #(
      .REGION_SIZE (8),
      .BLOCK_SIZE  (8),
      .ITEM_WIDTH  (8),
      .CHANNELS    (NCH),
      .CNTRS_WIDTH (CW)
   ) dut (
      .CLK                  (clk),
      .RESET                (rst),
      .RX_MFB_DATA          (rx_data),
      .RX_MFB_META          (rx_meta),
      .RX_MFB_SOF_POS       (rx_sof_pos),
      .RX_MFB_EOF_POS       (rx_eof_pos),
      .RX_MFB_SOF           (rx_sof),
      .RX_MFB_EOF           (rx_eof),
      .RX_MFB_SRC_RDY       (rx_src_rdy),
      .RX_MFB_DST_RDY       (rx_dst_rdy),
      .TX_MFB_DATA          (tx_data),
      .TX_MFB_META_CHAN     (tx_chan),
      .TX_MFB_META_HDR_META (tx_hdr),
      .TX_MFB_SOF_POS       (tx_sof_pos),
      .TX_MFB_EOF_POS       (tx_eof_pos),
      .TX_MFB_SOF           (tx_sof),
      .TX_MFB_EOF           (tx_eof),
      .TX_MFB_SRC_RDY       (tx_src_rdy),
      .TX_MFB_DST_RDY       (tx_dst_rdy),
      .CHAN_ENABLE          (chan_en),
      .CNT_CLR              (cnt_clr),
      .PASS_CNT             (pass_cnt),
      .DROP_CNT             (drop_cnt)
   );

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rand_data();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic int sat_add(input int v, input bit inc);
      int r;
      r = v + (inc ? 1 : 0);
      return (r > CMAX) ? CMAX : r;
   endfunction

   // One clock: check outputs at the falling edge, then advance the model
   // by what the next rising edge will do. Ends at rising edge + 1.
   task automatic step();
      bit    exp_vld;
      bit    acc;
      bit    drop;
      bit    inc_p;
      bit    inc_d;
      int    ch;
      word_t w;
      @(negedge clk);
      exp_vld = (exp_q.size() != 0);
      check("tx_src_rdy", tx_src_rdy, exp_vld);
      check("rx_dst_rdy", rx_dst_rdy, !exp_vld || tx_dst_rdy);
      if (exp_vld && tx_src_rdy === 1'b1) begin
         check("tx_data", tx_data, exp_q[0].data);
         check("tx_sof_pos", tx_sof_pos, exp_q[0].sp);
         check("tx_eof_pos", tx_eof_pos, exp_q[0].ep);
         check("tx_sof", tx_sof, exp_q[0].sof);
         check("tx_eof", tx_eof, exp_q[0].eof);
         check("tx_chan", tx_chan, exp_q[0].chan);
         check("tx_hdr", tx_hdr, exp_q[0].hdr);
      end
      check("pass_cnt", pass_cnt, m_pass);
      check("drop_cnt", drop_cnt, m_drop);

      acc = rx_src_rdy && (!exp_vld || tx_dst_rdy);
      last_acc = acc;
      if (exp_vld && tx_dst_rdy) void'(exp_q.pop_front());
      inc_p = 1'b0;
      inc_d = 1'b0;
      if (acc) begin
         ch = int'(rx_meta[27:24]);
         w.data = rx_data; w.sp = rx_sof_pos; w.ep = rx_eof_pos;
         w.sof = rx_sof;   w.eof = rx_eof;
         if (rx_sof) begin
            if (ch >= NCH) drop = 1'b1;
            else drop = !chan_en[ch];
            m_chan = rx_meta[27:24];
            m_hdr  = rx_meta[23:0];
            inc_p = !drop;
            inc_d = drop;
            in_pkt = !rx_eof;
            pkt_pass = !drop;
            w.chan = m_chan; w.hdr = m_hdr;
            if (!drop) exp_q.push_back(w);
         end else if (in_pkt) begin
            w.chan = m_chan; w.hdr = m_hdr;
            if (pkt_pass) exp_q.push_back(w);
            if (rx_eof) in_pkt = 1'b0;
         end
      end
      if (cnt_clr) begin
         m_pass = inc_p ? 1 : 0;
         m_drop = inc_d ? 1 : 0;
      end else begin
         m_pass = sat_add(m_pass, inc_p);
         m_drop = sat_add(m_drop, inc_d);
      end
      @(posedge clk);
      #1;
      if (tx_rand) tx_dst_rdy = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input bit sof, input bit eof, input int chan, input logic [23:0] hdr);
      int n;
      int sp;
      int ep;
      sp = $urandom_range(0, 7);
      ep = (sof && eof) ? $urandom_range(sp*8, 63) : $urandom_range(0, 63);
      assert (!(sof && eof) || (ep / 8 >= sp)) else $fatal(1, "FAIL precondition sof_pos %0d eof_pos %0d", sp, ep);
      rx_data    = rand_data();
      rx_meta    = {4'(chan), hdr};
      rx_sof_pos = 3'(sp);
      rx_eof_pos = 6'(ep);
      rx_sof     = sof;
      rx_eof     = eof;
      rx_src_rdy = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (!last_acc && n < 100);
      check("accept_timeout", last_acc, 1'b1);
      rx_src_rdy = 1'b0;
   endtask

   task automatic send_pkt(input int chan, input int len, input bit bubbles);
      logic [23:0] hdr;
      hdr = 24'($urandom);
      for (int i = 0; i < len; i++) begin
         send(i == 0, i == len - 1, chan, hdr);
         if (bubbles && $urandom_range(0, 4) == 0) step();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_src_rdy = 1'b0;
      cnt_clr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      in_pkt = 1'b0;
      m_pass = 0;
      m_drop = 0;
      @(negedge clk);
      check("rst_dst_rdy", rx_dst_rdy, 1'b1);
      check("rst_src_rdy", tx_src_rdy, 1'b0);
      check("rst_sof", tx_sof, 1'b0);
      check("rst_eof", tx_eof, 1'b0);
      check("rst_chan", tx_chan, 4'd0);
      check("rst_hdr", tx_hdr, 24'd0);
      check("rst_pass", pass_cnt, 4'd0);
      check("rst_drop", drop_cnt, 4'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      tx_rand = 1'b0;
      tx_dst_rdy = 1'b1;
      repeat (3) step();
      check("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      // reset and single-word packet on channel 3
      do_reset();
      chan_en = '1;
      tx_dst_rdy = 1'b1;
      send(1'b1, 1'b1, 3, 24'hABCDEF);
      step();
      check("t1_pass", pass_cnt, 4'd1);
      drain();

      // disabled channel 5 dropped, channel 6 forwarded
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
      chan_en[5] = 1'b0;
      send_pkt(5, 4, 1'b0);
      send_pkt(6, 2, 1'b0);
      drain();
      check("t2_pass", pass_cnt, 4'd1);
      check("t2_drop", drop_cnt, 4'd1);

      // enable withdrawn after SOF does not affect the packet
      chan_en = '1;
      send(1'b1, 1'b0, 2, 24'h123456);
      chan_en[2] = 1'b0;
      send(1'b0, 1'b0, 2, 24'h0);
      send(1'b0, 1'b1, 2, 24'h0);
      drain();

      // invalid channel number and a SOF arriving inside a packet
      chan_en = '1;
      send_pkt(13, 2, 1'b0);
      send(1'b1, 1'b0, 1, 24'h111111);
      send(1'b0, 1'b0, 1, 24'h0);
      send_pkt(4, 3, 1'b0);
      drain();

      // randomized packets with random downstream backpressure
      tx_rand = 1'b1;
      for (int p = 0; p < 200; p++) begin
         if ($urandom_range(0, 9) == 0) chan_en = NCH'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
         end
         send_pkt($urandom_range(0, 15), $urandom_range(1, 4), 1'b1);
      end
      drain();

      // counter saturation and clear coincident with an increment
      chan_en = '1;
      cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
      for (int p = 0; p < 17; p++) send_pkt(7, 1, 1'b0);
      drain();
      check("sat_pass", pass_cnt, 4'd15);
      cnt_clr = 1'b1;
      send(1'b1, 1'b1, 8, 24'h0F0F0F);
      cnt_clr = 1'b0;
      step();
      check("clr_inc_pass", pass_cnt, 4'd1);
      check("clr_inc_drop", drop_cnt, 4'd0);
      drain();

      // reset in the middle of a 5-word packet, tail arrives as orphans
      send(1'b1, 1'b0, 9, 24'h555555);
      send(1'b0, 1'b0, 9, 24'h0);
      do_reset();
      send(1'b0, 1'b0, 9, 24'h0);
      send(1'b0, 1'b0, 9, 24'h0);
      send(1'b0, 1'b1, 9, 24'h0);
      drain();
      check("orphan_pass", pass_cnt, 4'd0);
      check("orphan_drop", drop_cnt, 4'd0);
      send_pkt(10, 3, 1'b0);
      drain();
      check("post_rst_pass", pass_cnt, 4'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
